instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter WL_addr, default 32: width of wr_addr and load_len; addresses are word indices.
REQ-002 Parameter WL_data, default 32: instruction word width; SHALL be a multiple of 8; BYTES = WL_data/8.
REQ-003 Parameter DEPTH, default 32: number of writable instruction words, addresses 0..DEPTH-1.
REQ-004 Clocking: one clock, clk; reset is synchronous and active-low, rst_n.
REQ-005 Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  single-cycle request to begin a load session.
- load_len  in  WL_addr  number of words to load; sampled on accepted start.
- byte_in  in  8  stream byte, most-significant byte of each word first.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts byte_in this cycle.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  WL_addr  word index being written.
- wr_data  out  WL_data  assembled word.
- busy  out  1  session in progress; the CPU is held while high.
- done  out  1  session complete; held until the next accepted start or reset.
- err  out  1  load_len exceeded DEPTH; sticky until the next accepted start or reset.

Function
REQ-006 States: IDLE, RECV, WRITE, DONE; the state after reset is IDLE.
REQ-007 start is accepted only in IDLE or DONE; start in RECV or WRITE SHALL be ignored.
REQ-008 Start acceptance SHALL:
- latch len = min(load_len, DEPTH);
- set err = (load_len > DEPTH);
- clear done, the word index and the byte count.
REQ-009 On accepted start, the next state is RECV if len > 0, else DONE, with done=1 on the following cycle and no write.
REQ-010 byte_ready=1 only in RECV; a byte transfers on a cycle with byte_valid=1 and byte_ready=1.
REQ-011 In RECV, each transfer SHALL:
- shift the assembly register left 8 bits, inserting byte_in at bits [7:0];
- increment the byte count, 0..BYTES-1.
REQ-012 On the transfer of byte BYTES-1, the next state is WRITE and the byte count wraps to 0.
REQ-013 In WRITE, for exactly one cycle: wr_en=1, wr_addr=word index, wr_data=assembled word.
REQ-014 After WRITE:
- if word index+1 == len, the next state is DONE;
- otherwise the next state is RECV and the word index increments.
REQ-015 Bubble: byte_ready=0 in WRITE, giving one bubble cycle per word; minimum latency is BYTES+1 cycles per word.
REQ-016 byte_valid gaps SHALL stall the assembly without data loss; there is no timeout.
REQ-017 Output values by state:
- busy=1 in RECV and WRITE only;
- done=1 in DONE only;
- wr_en=0 outside WRITE;
- wr_addr/wr_data hold their last written values outside WRITE.
REQ-018 No write SHALL ever target an address >= DEPTH.

Reset
REQ-019 A cycle with rst_n=0 at the rising edge of clk SHALL force, on the next cycle:
- state IDLE;
- byte_ready=0, wr_en=0, busy=0, done=0, err=0;
- wr_addr=0, wr_data=0;
- assembly register, byte count, word index and len all 0.
REQ-020 Reset mid-session SHALL discard any partial word without issuing wr_en; words already written remain in memory.

Verification
REQ-021 Nominal load, load_len=2, bytes 20 08 00 05 00 00 00 00 -> wr_en at addr 0 data 0x20080005, then at addr 1 data 0x00000000; done=1, busy=0, err=0.
REQ-022 Zero length, start with load_len=0 -> done=1 the next cycle; wr_en never asserted; byte_ready stays 0.
REQ-023 Overlength, load_len=40 with DEPTH=32 -> err=1; exactly 32 writes, addresses 0..31; then done=1.
REQ-024 Gapped stream, byte_valid toggling every cycle, plus start pulsed during RECV -> same words and addresses as REQ-021; the start pulse has no effect.
REQ-025 Reset mid-word after 2 bytes -> no wr_en; all outputs at reset values; a new start with load_len=1 writes its word at addr 0.

Source files
------------

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: assembles MSB-first bytes into words and
// writes them to instruction memory while holding the CPU via busy.
module instr_loader #(
    parameter int WL_addr = 32,
    parameter int WL_data = 32,
    parameter int DEPTH   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WL_addr-1:0] load_len,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               wr_en,
    output logic [WL_addr-1:0] wr_addr,
    output logic [WL_data-1:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int BYTES = WL_data / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BC_W-1:0]    LAST_BYTE = BC_W'(BYTES - 1);
    localparam logic [WL_addr-1:0] DEPTH_W   = WL_addr'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WL_addr-1:0] len;
    logic [WL_addr-1:0] word_idx;
    logic [BC_W-1:0]    byte_cnt;
    logic [WL_data-1:0] asm_word;
    logic [WL_data-1:0] asm_next;
    logic [WL_addr-1:0] wr_addr_q;
    logic [WL_data-1:0] wr_data_q;
    logic               err_q;

    logic start_ok;
    logic xfer;
    logic last_byte;
    logic last_word;

    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign xfer      = (state == RECV) && byte_valid;
    assign last_byte = xfer && (byte_cnt == LAST_BYTE);
    assign last_word = ((word_idx + WL_addr'(1)) == len);
    assign asm_next  = WL_data'({asm_word, byte_in});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_next = (load_len == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (last_byte) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = last_word ? DONE : RECV;
            end
            default: state_next = IDLE;
        endcase
    end

    // The write address/data are captured on the final byte so they appear
    // during WRITE and then simply hold until the next word or reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len       <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            asm_word  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else if (start_ok) begin
            len      <= (load_len > DEPTH_W) ? DEPTH_W : load_len;
            err_q    <= (load_len > DEPTH_W);
            word_idx <= '0;
            byte_cnt <= '0;
            asm_word <= '0;
        end else begin
            if (xfer) begin
                asm_word <= asm_next;
                byte_cnt <= last_byte ? '0 : byte_cnt + BC_W'(1);
                if (last_byte) begin
                    wr_addr_q <= word_idx;
                    wr_data_q <= asm_next;
                end
            end
            if ((state == WRITE) && !last_word) begin
                word_idx <= word_idx + WL_addr'(1);
            end
        end
    end

    always_comb begin
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                byte_ready = 1'b0;
            end
        endcase
    end

    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: sessions are compared against a
// word-list model built directly from the byte stream and load length.
module tb_instr_loader;

    localparam int WL_ADDR = 32;
    localparam int WL_DATA = 32;
    localparam int DEPTH   = 32;
    localparam int BYTES   = WL_DATA / 8;

    typedef struct {
        logic [WL_ADDR-1:0] addr;
        logic [WL_DATA-1:0] data;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [WL_ADDR-1:0] load_len;
    logic [7:0]         byte_in;
    logic               byte_valid;
    logic               byte_ready;
    logic               wr_en;
    logic [WL_ADDR-1:0] wr_addr;
    logic [WL_DATA-1:0] wr_data;
    logic               busy;
    logic               done;
    logic               err;

    int checks = 0;
    int errors = 0;

    wr_t        wr_log[$];
    logic [7:0] stream[$];

    instr_loader #(
        .WL_addr(WL_ADDR),
        .WL_data(WL_DATA),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .load_len  (load_len),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Every observed write is logged; no write may ever leave the array.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_log.push_back('{addr: wr_addr, data: wr_data});
            checks++;
            if (wr_addr >= WL_ADDR'(DEPTH)) begin
                errors++;
                $display("[TB] FAIL write_range: wr_addr=%0d, required < %0d", wr_addr, DEPTH);
            end
        end
    end

    task automatic fill_random(input int nbytes);
        stream.delete();
        for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom_range(0, 255)));
    endtask

    // gap_mode: 0 = continuous, 1 = toggle every cycle, 2 = random
    task automatic run_session(input int len, input int gap_mode, input bit pulse_start,
                               input bit check_latency, input string name);
        wr_t  exp_q[$];
        int   n_exp;
        int   idx;
        int   cycles;
        bit   finished;
        bit   saw_ready;
        logic v;
        logic [WL_DATA-1:0] word;

        n_exp = (len > DEPTH) ? DEPTH : len;
        for (int w = 0; w < n_exp; w++) begin
            word = '0;
            for (int b = 0; b < BYTES; b++) word = {word[WL_DATA-9:0], stream[w*BYTES + b]};
            exp_q.push_back('{addr: WL_ADDR'(w), data: word});
        end

        wr_log.delete();
        @(negedge clk);
        start      = 1'b1;
        load_len   = WL_ADDR'(len);
        byte_valid = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        load_len  = $urandom;
        idx       = 0;
        cycles    = 1;
        finished  = 1'b0;
        saw_ready = 1'b0;
        while (cycles < 2000) begin
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (byte_ready) saw_ready = 1'b1;
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = cycles[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid = v && (idx < stream.size());
            byte_in    = (idx < stream.size()) ? stream[idx] : 8'($urandom);
            start      = pulse_start && (cycles == 3);
            if (byte_valid && byte_ready) idx++;
            @(negedge clk);
            cycles++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;

        checks++;
        if (!finished) begin
            errors++;
            $display("[TB] FAIL %s_timeout: done never seen within %0d cycles", name, cycles);
        end
        checks++;
        if (wr_log.size() !== n_exp) begin
            errors++;
            $display("[TB] FAIL %s_write_count: got %0d, expected %0d", name, wr_log.size(), n_exp);
        end
        for (int i = 0; i < n_exp && i < wr_log.size(); i++) begin
            checks++;
            if (wr_log[i].addr !== exp_q[i].addr || wr_log[i].data !== exp_q[i].data) begin
                errors++;
                $display("[TB] FAIL %s_write%0d: got addr %0d data %h, expected addr %0d data %h",
                         name, i, wr_log[i].addr, wr_log[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if ({done, busy, byte_ready, wr_en, err} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'(len > DEPTH)}) begin
            errors++;
            $display("[TB] FAIL %s_final_flags: got done/busy/ready/wr_en/err=%b, expected %b",
                     name, {done, busy, byte_ready, wr_en, err}, {1'b1, 1'b0, 1'b0, 1'b0, 1'(len > DEPTH)});
        end
        if (n_exp > 0) begin
            checks++;
            if (wr_addr !== exp_q[n_exp-1].addr || wr_data !== exp_q[n_exp-1].data) begin
                errors++;
                $display("[TB] FAIL %s_hold: got addr %0d data %h, expected addr %0d data %h",
                         name, wr_addr, wr_data, exp_q[n_exp-1].addr, exp_q[n_exp-1].data);
            end
        end else begin
            checks++;
            if (saw_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s_no_ready: byte_ready seen=%b, expected 0", name, saw_ready);
            end
        end
        if (check_latency) begin
            checks++;
            if (cycles !== (BYTES + 1) * n_exp + 1) begin
                errors++;
                $display("[TB] FAIL %s_latency: done after %0d cycles, expected %0d",
                         name, cycles, (BYTES + 1) * n_exp + 1);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_done_held: got %b, expected 1", name, done);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({byte_ready, wr_en, busy, done, err, wr_addr, wr_data} !== '0) begin
            errors++;
            $display("[TB] FAIL %s: ready/wr_en/busy/done/err=%b addr=%h data=%h, expected all 0",
                     name, {byte_ready, wr_en, busy, done, err}, wr_addr, wr_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        stream.delete();
        stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        run_session(2, 0, 1'b0, 1'b1, "nominal");
    endtask

    task automatic test_zero_length();
        stream.delete();
        run_session(0, 0, 1'b0, 1'b1, "zero_len");
    endtask

    task automatic test_overlength();
        fill_random(40 * BYTES);
        run_session(40, 0, 1'b0, 1'b1, "overlength");
    endtask

    task automatic test_gapped();
        stream.delete();
        stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        run_session(2, 1, 1'b1, 1'b0, "gapped");
    endtask

    task automatic test_mid_reset();
        fill_random(BYTES);
        wr_log.delete();
        @(negedge clk);
        start    = 1'b1;
        load_len = WL_ADDR'(1);
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'hA5;
        @(negedge clk);
        byte_in = 8'h5A;
        @(negedge clk);
        byte_valid = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset_outputs");
        rst_n = 1'b1;
        checks++;
        if (wr_log.size() !== 0) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_write: got %0d writes, expected 0", wr_log.size());
        end
        run_session(1, 0, 1'b0, 1'b1, "after_reset");
    endtask

    task automatic test_back_to_back();
        int len;
        for (int s = 0; s < 8; s++) begin
            len = (s == 5) ? DEPTH + 1 + $urandom_range(0, 3) : $urandom_range(0, 6);
            fill_random(len * BYTES);
            run_session(len, 2, 1'($urandom_range(0, 1)), 1'b0, $sformatf("random%0d", s));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        load_len   = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        test_reset();
        test_nominal();
        test_zero_length();
        test_overlength();
        test_gapped();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
